// File: rtl/int_controller.sv
// Interrupt scheduler between four peripheral IRQ lines and the VeSPA CPU interrupt port.
// Optional rotating priority is enabled by defining INTC_ROUND_ROBIN_EN.
module int_controller #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] MASK_RST    = 4'b0000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_IrqSrc,
  input  logic       i_MaskWe,
  input  logic [3:0] i_MaskWData,
  input  logic       i_IntAckAttended,
  input  logic       i_IntAckComplete,
  output logic       o_IntRequest,
  output logic [1:0] o_IntNumber,
  output logic       o_IntPending,
  output logic [3:0] o_IrqMask,
  output logic [3:0] o_PendingVec,
  output logic [1:0] o_FsmState
);

  // Handshake: o_IntRequest is raised in IDLE and held with o_IntNumber until the CPU
  // pulses i_IntAckAttended; o_IntPending is then held until i_IntAckComplete. Acks
  // arriving in any other state are ignored, and Attended takes precedence in REQ.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t                        r_State;
  logic [SYNC_STAGES-1:0][3:0]   r_Sync;
  logic [3:0]                    r_SyncPrev;
  logic [3:0]                    r_Pending;
  logic [3:0]                    r_Mask;
  logic                          r_IntRequest;
  logic [1:0]                    r_IntNumber;
  logic                          r_IntPending;

  logic [3:0]                    w_SyncOut;
  logic [3:0]                    w_Rise;
  logic [3:0]                    w_Eligible;
  logic [3:0]                    w_AttendClr;
  logic                          w_Attend;
  logic                          w_SelValid;
  logic [1:0]                    w_SelNum;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_Sync     <= '0;
      r_SyncPrev <= 4'b0000;
    end else begin
      r_Sync[0] <= i_IrqSrc;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_Sync[s] <= r_Sync[s-1];
      end
      r_SyncPrev <= w_SyncOut;
    end
  end

  assign w_SyncOut   = r_Sync[SYNC_STAGES-1];
  assign w_Rise      = w_SyncOut & ~r_SyncPrev;
  assign w_Attend    = (r_State == REQ) && i_IntAckAttended;
  assign w_AttendClr = w_Attend ? (4'b0001 << r_IntNumber) : 4'b0000;
  assign w_Eligible  = r_Pending & r_Mask;

  // A fresh edge in the same cycle as the service clear re-arms the bit.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_Pending <= 4'b0000;
    end else begin
      r_Pending <= (r_Pending & ~w_AttendClr) | w_Rise;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_Mask <= MASK_RST;
    end else if (i_MaskWe) begin
      r_Mask <= i_MaskWData;
    end
  end

`ifdef INTC_ROUND_ROBIN_EN
  logic [1:0] r_RrPtr;
  logic [1:0] w_Idx;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_RrPtr <= 2'd0;
    end else if (w_Attend) begin
      r_RrPtr <= r_IntNumber + 2'd1;
    end
  end

  // Search from the pointer upward with wrap; the smallest offset wins.
  always_comb begin
    w_Idx      = 2'd0;
    w_SelNum   = 2'd0;
    w_SelValid = |w_Eligible;
    for (int k = 3; k >= 0; k--) begin
      w_Idx = r_RrPtr + 2'(k);
      if (w_Eligible[w_Idx]) begin
        w_SelNum = w_Idx;
      end
    end
  end
`else
  always_comb begin
    w_SelNum   = 2'd0;
    w_SelValid = |w_Eligible;
    for (int i = 3; i >= 0; i--) begin
      if (w_Eligible[i]) begin
        w_SelNum = 2'(i);
      end
    end
  end
`endif

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_State      <= IDLE;
      r_IntRequest <= 1'b0;
      r_IntNumber  <= 2'd0;
      r_IntPending <= 1'b0;
    end else begin
      case (r_State)
        IDLE: begin
          r_IntRequest <= 1'b0;
          r_IntPending <= 1'b0;
          if (w_SelValid) begin
            r_IntNumber  <= w_SelNum;
            r_IntRequest <= 1'b1;
            r_State      <= REQ;
          end
        end
        REQ: begin
          if (i_IntAckAttended) begin
            r_IntRequest <= 1'b0;
            r_IntPending <= 1'b1;
            r_State      <= SVC;
          end
        end
        SVC: begin
          if (i_IntAckComplete) begin
            r_IntPending <= 1'b0;
            r_State      <= IDLE;
          end
        end
        default: begin
          r_IntRequest <= 1'b0;
          r_IntPending <= 1'b0;
          r_State      <= IDLE;
        end
      endcase
    end
  end

  assign o_IntRequest = r_IntRequest;
  assign o_IntNumber  = r_IntNumber;
  assign o_IntPending = r_IntPending;
  assign o_IrqMask    = r_Mask;
  assign o_PendingVec = r_Pending;
  assign o_FsmState   = r_State;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: capture latency, handshake, priority, masking,
// coincident set/clear and asynchronous reset.
module tb_int_controller;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SVC  = 2'd2;
  localparam logic [3:0] MASK_RST = 4'b0000;

  logic       clk;
  logic       rst_n;
  logic [3:0] irq_src;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       ack_att;
  logic       ack_cmp;
  logic       int_req;
  logic [1:0] int_num;
  logic       int_pend;
  logic [3:0] irq_mask;
  logic [3:0] pend_vec;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  int_controller #(.SYNC_STAGES(2), .MASK_RST(MASK_RST)) dut (
    .i_Clk           (clk),
    .i_Rst           (rst_n),
    .i_IrqSrc        (irq_src),
    .i_MaskWe        (mask_we),
    .i_MaskWData     (mask_wdata),
    .i_IntAckAttended(ack_att),
    .i_IntAckComplete(ack_cmp),
    .o_IntRequest    (int_req),
    .o_IntNumber     (int_num),
    .o_IntPending    (int_pend),
    .o_IrqMask       (irq_mask),
    .o_PendingVec    (pend_vec),
    .o_FsmState      (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  logic [1:0] first_num;
  logic [1:0] second_num;

  initial begin
`ifdef INTC_ROUND_ROBIN_EN
    first_num  = 2'd3;
    second_num = 2'd1;
`else
    first_num  = 2'd1;
    second_num = 2'd3;
`endif
    rst_n = 1'b0; irq_src = 4'b0000; mask_we = 1'b0; mask_wdata = 4'b0000;
    ack_att = 1'b0; ack_cmp = 1'b0;
    tick(3);
    check("rst_req",   {3'b0, int_req},  4'h0);
    check("rst_num",   {2'b0, int_num},  4'h0);
    check("rst_pend",  {3'b0, int_pend}, 4'h0);
    check("rst_mask",  irq_mask,         MASK_RST);
    check("rst_pvec",  pend_vec,         4'h0);
    check("rst_state", {2'b0, fsm_state}, {2'b0, ST_IDLE});
    rst_n = 1'b1;
    tick();
    write_mask(4'b1111);
    check("mask_rb", irq_mask, 4'b1111);

    // 1: source 2 pulse, request exactly four edges after the rise
    irq_src = 4'b0100;
    tick(3);
    check("t1_pvec",   pend_vec, 4'b0100);
    check("t1_noreq3", {3'b0, int_req}, 4'h0);
    irq_src = 4'b0000;
    tick();
    check("t1_req",  {3'b0, int_req}, 4'h1);
    check("t1_num",  {2'b0, int_num}, 4'h2);

    // 2: handshake, with out-of-state acks ignored
    ack_cmp = 1'b1; tick(); ack_cmp = 1'b0;
    check("t2_cmp_ign_st",  {2'b0, fsm_state}, {2'b0, ST_REQ});
    check("t2_cmp_ign_req", {3'b0, int_req}, 4'h1);
    ack_att = 1'b1; tick(); ack_att = 1'b0;
    check("t2_req0",  {3'b0, int_req},  4'h0);
    check("t2_pend1", {3'b0, int_pend}, 4'h1);
    check("t2_pvec",  pend_vec, 4'b0000);
    check("t2_num",   {2'b0, int_num}, 4'h2);
    ack_att = 1'b1; tick(); ack_att = 1'b0;
    check("t2_att_ign", {2'b0, fsm_state}, {2'b0, ST_SVC});
    ack_cmp = 1'b1; tick(); ack_cmp = 1'b0;
    check("t2_pend0", {3'b0, int_pend}, 4'h0);
    check("t2_idle",  {2'b0, fsm_state}, {2'b0, ST_IDLE});

    // 3: simultaneous sources 3 and 1
    irq_src = 4'b1010;
    tick(4);
    irq_src = 4'b0000;
    check("t3_req1", {3'b0, int_req}, 4'h1);
    check("t3_num1", {2'b0, int_num}, {2'b0, first_num});
    ack_att = 1'b1; tick(); ack_att = 1'b0;
    check("t3_pvec1", pend_vec, 4'b1010 & ~(4'b0001 << first_num));
    ack_cmp = 1'b1; tick(); ack_cmp = 1'b0;
    check("t3_gap_req", {3'b0, int_req}, 4'h0);
    tick();
    check("t3_req2", {3'b0, int_req}, 4'h1);
    check("t3_num2", {2'b0, int_num}, {2'b0, second_num});
    ack_att = 1'b1; ack_cmp = 1'b1; tick(); ack_att = 1'b0; ack_cmp = 1'b0;
    check("t3_both_st",   {2'b0, fsm_state}, {2'b0, ST_SVC});
    check("t3_both_pend", {3'b0, int_pend}, 4'h1);
    ack_cmp = 1'b1; tick(); ack_cmp = 1'b0;
    check("t3_idle", {2'b0, fsm_state}, {2'b0, ST_IDLE});

    // 4: masked source latches pending but does not request until unmasked
    write_mask(4'b0000);
    irq_src = 4'b0001;
    tick(5);
    check("t4_pvec",  pend_vec, 4'b0001);
    check("t4_noreq", {3'b0, int_req}, 4'h0);
    write_mask(4'b0001);
    check("t4_oldmask", {3'b0, int_req}, 4'h0);
    tick();
    check("t4_req", {3'b0, int_req}, 4'h1);
    check("t4_num", {2'b0, int_num}, 4'h0);
    irq_src = 4'b0000;
    ack_att = 1'b1; tick(); ack_att = 1'b0;
    ack_cmp = 1'b1; tick(); ack_cmp = 1'b0;
    check("t4_pvec0", pend_vec, 4'b0000);

    // 5: new edge on source 1 lands on its Attended edge
    write_mask(4'b1111);
    irq_src = 4'b0010;
    tick(4);
    check("t5_req", {3'b0, int_req}, 4'h1);
    check("t5_num", {2'b0, int_num}, 4'h1);
    irq_src = 4'b0000;
    tick(3);
    irq_src = 4'b0010;
    tick(2);
    ack_att = 1'b1; tick(); ack_att = 1'b0;
    check("t5_keep", pend_vec, 4'b0010);
    check("t5_svc",  {2'b0, fsm_state}, {2'b0, ST_SVC});
    ack_cmp = 1'b1; tick(); ack_cmp = 1'b0;
    tick();
    check("t5_req2", {3'b0, int_req}, 4'h1);
    check("t5_num2", {2'b0, int_num}, 4'h1);

    // 6: asynchronous reset while in service with another event pending
    ack_att = 1'b1; tick(); ack_att = 1'b0;
    irq_src = 4'b1000;
    tick(3);
    check("t6_pre_pvec", pend_vec, 4'b1000);
    check("t6_pre_pend", {3'b0, int_pend}, 4'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_req",  {3'b0, int_req},  4'h0);
    check("t6_pend", {3'b0, int_pend}, 4'h0);
    check("t6_num",  {2'b0, int_num},  4'h0);
    check("t6_pvec", pend_vec, 4'h0);
    check("t6_mask", irq_mask, MASK_RST);
    check("t6_st",   {2'b0, fsm_state}, {2'b0, ST_IDLE});
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
